// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester arbiter for a single shared register file port
// Optional macro REGFILE_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default round-robin).
module regfile_arbiter #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [ADDR-1:0]  addr0,
  input  logic [ADDR-1:0]  addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] rdata,
  output logic             rf_wr_en,
  output logic             rf_rd_en,
  output logic [ADDR-1:0]  rf_addr,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic [WIDTH-1:0] rf_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rf_wr_en_q, rf_wr_en_d;
  logic             rf_rd_en_q, rf_rd_en_d;
  logic [ADDR-1:0]  rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic             wr_q, wr_d;
  logic             win;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  always_comb win = ~req0;
`else
  // last_q names the requester granted most recently; a tie goes to the other one
  logic last_q, last_d;

  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_q;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (req0 || req1)) last_d = win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    rdata_d    = rdata_q;
    rf_wr_en_d = 1'b0;
    rf_rd_en_d = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    wr_d       = wr_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d      = win ? 2'b10 : 2'b01;
          wr_d       = win ? wr1 : wr0;
          rf_addr_d  = win ? addr1 : addr0;
          rf_wdata_d = win ? wdata1 : wdata0;
          // strobes are registered, so they are raised on the way into ACCESS
          rf_wr_en_d = wr_d;
          rf_rd_en_d = ~wr_d;
          state_d    = ACCESS;
        end
      end
      ACCESS: state_d = WAIT;
      WAIT: begin
        if (!wr_q) rdata_d = rf_rdata;
        done_d  = gnt_q;
        state_d = DONE;
      end
      DONE: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      rf_wr_en_q <= 1'b0;
      rf_rd_en_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_rd_en_q <= rf_rd_en_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      wr_q       <= wr_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign rf_wr_en = rf_wr_en_q;
  assign rf_rd_en = rf_rd_en_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - randomized self-checking bench for regfile_arbiter
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [2:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  gnt, done;
  logic [15:0] rdata;
  logic        rf_wr_en, rf_rd_en;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] rf_mem  [8];
  logic [15:0] ref_mem [8];
  logic        ref_last;
  logic [15:0] ref_rdata;
  logic [1:0]  gnt_log [$];

  regfile_arbiter #(.WIDTH(16), .ADDR(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wr_en) rf_mem[rf_addr] <= rf_wdata;
    if (rf_rd_en) rf_rdata <= rf_mem[rf_addr];
  end

  logic prev_wr = 1'b0, prev_rd = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (gnt == 2'b11) begin
        n_err++; $display("FAIL gnt_onehot: gnt=%b required one-hot or zero", gnt);
      end
      n_cmp++;
      if (rf_wr_en && rf_rd_en) begin
        n_err++; $display("FAIL strobe_excl: wr_en=1 rd_en=1 required not both");
      end
      n_cmp++;
      if ((rf_wr_en && prev_wr) || (rf_rd_en && prev_rd)) begin
        n_err++; $display("FAIL strobe_pulse: strobe high 2 cycles required single-cycle");
      end
    end
    prev_wr = rf_wr_en;
    prev_rd = rf_rd_en;
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    #2;
    reset = 1'b0;
    ref_last  = 1'b1;
    ref_rdata = '0;
  endtask

  // One transaction of the model: pick the winner, run four edges, check each.
  task automatic do_txn(input bit drop_early);
    logic [1:0]  g;
    logic        w;
    logic [2:0]  a;
    logic [15:0] d;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    if (req0 && req1) g = 2'b01;
`else
    if (req0 && req1) g = ref_last ? 2'b01 : 2'b10;
`endif
    else g = req0 ? 2'b01 : 2'b10;
    ref_last = g[1];
    w = g[0] ? wr0 : wr1;
    a = g[0] ? addr0 : addr1;
    d = g[0] ? wdata0 : wdata1;
    if (w) ref_mem[a] = d;
    else   ref_rdata = ref_mem[a];
    gnt_log.push_back(g);

    @(posedge clk); #1;
    n_cmp++;
    if (gnt !== g || rf_wr_en !== w || rf_rd_en !== !w || rf_addr !== a || done !== 2'b00) begin
      n_err++;
      $display("FAIL access: gnt=%b wr=%b rd=%b addr=%0d done=%b required gnt=%b wr=%b rd=%b addr=%0d done=00",
               gnt, rf_wr_en, rf_rd_en, rf_addr, done, g, w, !w, a);
    end
    if (w) begin
      n_cmp++;
      if (rf_wdata !== d) begin
        n_err++; $display("FAIL access_wdata: rf_wdata=%h required %h", rf_wdata, d);
      end
    end

    @(posedge clk); #1;
    n_cmp++;
    if (rf_wr_en !== 1'b0 || rf_rd_en !== 1'b0 || gnt !== g || done !== 2'b00) begin
      n_err++;
      $display("FAIL wait: wr=%b rd=%b gnt=%b done=%b required 0 0 %b 00", rf_wr_en, rf_rd_en, gnt, done, g);
    end
    if (drop_early) begin
      if (g[0]) req0 = 1'b0;
      else      req1 = 1'b0;
    end

    @(posedge clk); #1;
    n_cmp++;
    if (done !== g || gnt !== g || rdata !== ref_rdata) begin
      n_err++;
      $display("FAIL done: done=%b gnt=%b rdata=%h required %b %b %h", done, gnt, rdata, g, g, ref_rdata);
    end

    @(posedge clk); #1;
    n_cmp++;
    if (done !== 2'b00 || gnt !== 2'b00) begin
      n_err++; $display("FAIL idle: done=%b gnt=%b required 00 00", done, gnt);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (gnt !== 2'b00 || done !== 2'b00 || rf_wr_en !== 1'b0 || rf_rd_en !== 1'b0 ||
        rf_addr !== 3'd0 || rf_wdata !== 16'h0 || rdata !== 16'h0) begin
      n_err++;
      $display("FAIL reset: gnt=%b done=%b wr=%b rd=%b addr=%0d wdata=%h rdata=%h required all zero",
               gnt, done, rf_wr_en, rf_rd_en, rf_addr, rf_wdata, rdata);
    end
    apply_reset();
  endtask

  task automatic test_latency();
    apply_reset();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd2; wdata0 = 16'h0002;
    do_txn(1'b0);
    req0 = 1'b0;
    n_cmp++;
    if (rf_mem[2] !== 16'h0002) begin
      n_err++; $display("FAIL latency_store: mem[2]=%h required 0002", rf_mem[2]);
    end
  endtask

  task automatic test_write_read();
    req1 = 1'b1; wr1 = 1'b1; addr1 = 3'd3; wdata1 = 16'h0003;
    do_txn(1'b0);
    req1 = 1'b0;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd3;
    do_txn(1'b0);
    req0 = 1'b0;
    n_cmp++;
    if (rdata !== 16'h0003) begin
      n_err++; $display("FAIL write_read: rdata=%h required 0003", rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [4];
    logic [1:0] g;
    apply_reset();
    gnt_log.delete();
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    req0 = 1'b1; req1 = 1'b1;
    wr0 = 1'b0; wr1 = 1'b0; addr0 = 3'd1; addr1 = 3'd6;
    for (int i = 0; i < 4; i++) do_txn(1'b0);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g = gnt_log[i];
      n_cmp++;
      if (g !== exp_seq[i]) begin
        n_err++; $display("FAIL rr_seq%0d: gnt=%b required %b", i, g, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_during_access();
    logic [15:0] old;
    apply_reset();
    old = ref_mem[5];
    req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd5; wdata0 = ~old;
    @(posedge clk); #1;
    n_cmp++;
    if (rf_wr_en !== 1'b1 || gnt !== 2'b01) begin
      n_err++; $display("FAIL abort_pre: wr=%b gnt=%b required 1 01", rf_wr_en, gnt);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (rf_wr_en !== 1'b0 || gnt !== 2'b00) begin
      n_err++; $display("FAIL abort_drop: wr=%b gnt=%b required 0 00", rf_wr_en, gnt);
    end
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0;
    ref_last = 1'b1; ref_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 2'b00) begin
        n_err++; $display("FAIL abort_done%0d: done=%b required 00", i, done);
      end
    end
    n_cmp++;
    if (rf_mem[5] !== old) begin
      n_err++; $display("FAIL abort_mem: mem[5]=%h required %h", rf_mem[5], old);
    end
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; addr0 = 3'd5; addr1 = 3'd4;
    do_txn(1'b0);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_drop_mid();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd2; wdata0 = 16'($urandom);
    do_txn(1'b0);
    req0 = 1'b0;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd2;
    do_txn(1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if (gnt !== 2'b00 || rf_wr_en !== 1'b0 || rf_rd_en !== 1'b0) begin
      n_err++; $display("FAIL drop_idle: gnt=%b wr=%b rd=%b required 00 0 0", gnt, rf_wr_en, rf_rd_en);
    end
  endtask

  task automatic test_random();
    logic [1:0] m;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(1, 3));
      req0 = m[0]; req1 = m[1];
      wr0 = 1'($urandom_range(0, 1)); wr1 = 1'($urandom_range(0, 1));
      addr0 = 3'($urandom_range(0, 7)); addr1 = 3'($urandom_range(0, 7));
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      do_txn(1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 16'($urandom);
      rf_mem[i]  = ref_mem[i];
    end
    ref_last  = 1'b1;
    ref_rdata = '0;
    test_reset();
    test_latency();
    test_write_read();
    test_round_robin();
    test_reset_during_access();
    test_drop_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
